// File: rtl/modulo_multiplexador_displays_pkg.sv
// Shared definitions for the four-digit 7-segment display multiplexer.
// Holds the digit count, the all-off digit-select pattern, the digit-index
// type and small helpers used to pick nibbles and digit enables.
package modulo_multiplexador_displays_pkg;

    localparam int         N_DIGITS = 4;
    localparam logic [3:0] DIG_OFF  = 4'b1111;

    // Digit index: 0 is the rightmost digit, 3 the leftmost.
    typedef logic [1:0] digit_idx_t;

    // Nibble of a four-digit word selected by digit index.
    function automatic logic [3:0] nibble_at(input logic [15:0] v, input digit_idx_t i);
        return v[{i, 2'b00} +: 4];
    endfunction

    // Active-low one-cold digit enable for the given index.
    function automatic logic [3:0] digit_sel_n(input digit_idx_t i);
        return ~(4'b0001 << i);
    endfunction

    // True when digit i is a leading zero: its nibble and every more
    // significant nibble are zero. Digit 0 is never a leading zero so a
    // zero value still shows a single "0".
    function automatic logic is_leading_zero(input logic [15:0] v, input digit_idx_t i);
        logic z;
        z = (i != 2'd0);
        for (int k = 0; k < N_DIGITS; k++) begin
            if ((k >= int'(i)) && (v[4*k +: 4] != 4'h0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/modulo_multiplexador_displays_prescaler.sv
// Slot-timing prescaler: counts 0..PRESCALE-1 while EN is high, cleared when low.
// Latency: TC is combinational, high in the last cycle of each PRESCALE-cycle slot.
// Backpressure: none; EN low holds the count at 0 so the next slot starts full length.
module modulo_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic EN,
    output logic TC
);

    localparam int             CW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign TC     = EN && w_last;

    // Free-running slot counter, wraps on terminal count, parked at 0 when disabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (!EN) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/modulo_multiplexador_displays.sv
// Four-digit multiplexed 7-segment driver: scans digits 0..3, PRESCALE cycles each.
// Latency: D7SEG/DIG_SEL registered, updated on the same edge as the digit index.
// Backpressure: none; LOAD always accepted, new value shown from the next frame wrap.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always lit).
module modulo_multiplexador_displays
    import modulo_multiplexador_displays_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        LOAD,
    input  logic [15:0] VALUE,
    input  logic        ENABLE,
    output logic [3:0]  D7SEG,
    output logic [3:0]  DIG_SEL,
    output logic        TICK
);

    // ENABLE delayed by one cycle. The edge that first sees ENABLE high
    // lights digit 0; holding the prescaler idle on that edge gives digit 0
    // a full PRESCALE-cycle slot after (re)enable.
    logic        r_en_q;
    logic        w_pre_en;
    logic        w_tc;
    logic        w_wrap;

    digit_idx_t  r_idx;
    digit_idx_t  w_idx_nxt;
    logic [15:0] r_pending;
    logic [15:0] w_pending_nxt;
    logic [15:0] r_display;
    logic [15:0] w_display_nxt;
    logic        w_blank;
    logic [3:0]  w_dig_sel_nxt;

    assign w_pre_en = ENABLE && r_en_q;
    assign w_wrap   = w_tc && (r_idx == digit_idx_t'(N_DIGITS - 1));

    modulo_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .EN      (w_pre_en),
        .TC      (w_tc)
    );

    // Next digit index, pending and display words.
    always_comb begin
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_display_nxt = r_display;

        if (LOAD) begin
            w_pending_nxt = VALUE;
        end

        if (!ENABLE) begin
            // Nothing is being scanned, so the display word can follow
            // pending freely without tearing a frame.
            w_idx_nxt     = '0;
            w_display_nxt = r_pending;
        end else if (w_tc) begin
            w_idx_nxt = r_idx + 1'b1;
            if (w_wrap) begin
                // Uses the post-LOAD pending value so a LOAD on the wrap
                // edge goes straight into the frame that starts here.
                w_display_nxt = w_pending_nxt;
            end
        end
    end

    // Leading-zero blanking decision for the digit about to be shown.
    always_comb begin
        w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = is_leading_zero(w_display_nxt, w_idx_nxt);
`endif
    end

    // Digit enable pattern for the digit about to be shown.
    always_comb begin
        w_dig_sel_nxt = digit_sel_n(w_idx_nxt);
        if (!ENABLE || w_blank) begin
            w_dig_sel_nxt = DIG_OFF;
        end
    end

    // Scan state: enable history, digit index, pending and display words.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_en_q    <= 1'b0;
            r_idx     <= '0;
            r_pending <= '0;
            r_display <= '0;
        end else begin
            r_en_q    <= ENABLE;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_display <= w_display_nxt;
        end
    end

    // Registered outputs, aligned with the index they describe.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            D7SEG   <= 4'h0;
            DIG_SEL <= DIG_OFF;
            TICK    <= 1'b0;
        end else begin
            D7SEG   <= nibble_at(w_display_nxt, w_idx_nxt);
            DIG_SEL <= w_dig_sel_nxt;
            TICK    <= w_tc;
        end
    end

endmodule
